// File: rtl/clint_if.sv
// Request/response bus between a requester and the CLINT timer block.
// Request:  i_clint_valid / o_clint_ready with wen, addr, wdata, wmask.
// Response: o_clint_rvalid / i_clint_rready with rdata (reads and writes).
// Modports: master = requester side, slave = clint_timer side.
interface clint_if;
   logic        i_clint_valid;
   logic        o_clint_ready;
   logic        i_clint_wen;
   logic [63:0] i_clint_addr;
   logic [63:0] i_clint_wdata;
   logic [7:0]  i_clint_wmask;
   logic        o_clint_rvalid;
   logic [63:0] o_clint_rdata;
   logic        i_clint_rready;

   modport master (
      output i_clint_valid, i_clint_wen, i_clint_addr, i_clint_wdata,
             i_clint_wmask, i_clint_rready,
      input  o_clint_ready, o_clint_rvalid, o_clint_rdata
   );

   modport slave (
      input  i_clint_valid, i_clint_wen, i_clint_addr, i_clint_wdata,
             i_clint_wmask, i_clint_rready,
      output o_clint_ready, o_clint_rvalid, o_clint_rdata
   );
endinterface

// File: rtl/clint_timer.sv
// Core-local interruptor: free-running mtime, mtimecmp compare and optional
// machine software interrupt register behind a valid/ready request bus.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   bus (clint_if.slave) - register access request/response channel
//   o_clint_timer_intr  - registered level, mtime >= mtimecmp (unsigned)
//   o_clint_soft_intr   - registered msip[0]
// Optional feature: define CLINT_MSIP_EN to build the msip register;
// otherwise msip reads 0, ignores writes and o_clint_soft_intr is 0.
module clint_timer #(
   parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic   clk,
   input  logic   rst_n,
   clint_if.slave bus,
   output logic   o_clint_timer_intr,
   output logic   o_clint_soft_intr
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

   localparam logic [63:0] ADDR_MSIP     = BASE_ADDR;
   localparam logic [63:0] ADDR_MTIMECMP = BASE_ADDR + 64'h4000;
   localparam logic [63:0] ADDR_MTIME    = BASE_ADDR + 64'hBFF8;

   typedef enum logic {IDLE, RESP} state_t;

   state_t             state;
   logic               ready_q;
   logic               rvalid_q;
   logic [63:0]        rdata_q;
   logic [CNT_W-1:0]   tick_cnt;
   logic [63:0]        mtime;
   logic [63:0]        mtimecmp;
   logic               timer_intr_q;

   logic               accept_c;
   logic               wr_c;
   logic               sel_msip_c;
   logic               sel_mtimecmp_c;
   logic               sel_mtime_c;
   logic               tick_c;
   logic [63:0]        mtime_inc_c;
   logic [63:0]        mtime_next_c;
   logic [63:0]        msip_rd_c;
   logic [63:0]        rd_mux_c;

   // Byte-wise merge of new data over an old value under a byte mask.
   function automatic logic [63:0] merge(input logic [63:0] old_v,
                                         input logic [63:0] new_v,
                                         input logic [7:0]  mask);
      logic [63:0] r;
      r = old_v;
      for (int i = 0; i < 8; i++) begin
         if (mask[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

   assign accept_c       = (state == IDLE) && bus.i_clint_valid;
   assign wr_c           = accept_c && bus.i_clint_wen;
   assign sel_msip_c     = (bus.i_clint_addr == ADDR_MSIP);
   assign sel_mtimecmp_c = (bus.i_clint_addr == ADDR_MTIMECMP);
   assign sel_mtime_c    = (bus.i_clint_addr == ADDR_MTIME);

   assign tick_c      = (tick_cnt == TICK_LAST);
   assign mtime_inc_c = tick_c ? (mtime + 64'd1) : mtime;
   // Written bytes win; unwritten bytes take the (possibly incremented) old value.
   assign mtime_next_c = (wr_c && sel_mtime_c)
                       ? merge(mtime_inc_c, bus.i_clint_wdata, bus.i_clint_wmask)
                       : mtime_inc_c;

`ifdef CLINT_MSIP_EN
   logic msip;

   // Only bit 0 of msip exists; upper bits read as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msip <= 1'b0;
      end else if (wr_c && sel_msip_c && bus.i_clint_wmask[0]) begin
         msip <= bus.i_clint_wdata[0];
      end
   end

   assign msip_rd_c         = {63'd0, msip};
   assign o_clint_soft_intr = msip;
`else
   assign msip_rd_c         = 64'd0;
   assign o_clint_soft_intr = 1'b0;
`endif

   // Read mux on current (pre-tick) register values; unmapped reads return 0.
   always_comb begin
      rd_mux_c = 64'd0;
      if (sel_msip_c)          rd_mux_c = msip_rd_c;
      else if (sel_mtimecmp_c) rd_mux_c = mtimecmp;
      else if (sel_mtime_c)    rd_mux_c = mtime;
   end

   // Handshake FSM with registered ready/rvalid/rdata.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rdata_q  <= 64'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_clint_valid) begin
                  state    <= RESP;
                  ready_q  <= 1'b0;
                  rvalid_q <= 1'b1;
                  rdata_q  <= bus.i_clint_wen ? 64'd0 : rd_mux_c;
               end
            end
            RESP: begin
               if (bus.i_clint_rready) begin
                  state    <= IDLE;
                  ready_q  <= 1'b1;
                  rvalid_q <= 1'b0;
                  rdata_q  <= 64'd0;
               end
            end
            default: begin
               state    <= IDLE;
               ready_q  <= 1'b1;
               rvalid_q <= 1'b0;
               rdata_q  <= 64'd0;
            end
         endcase
      end
   end

   // Timebase, compare register and interrupt level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt     <= '0;
         mtime        <= 64'd0;
         mtimecmp     <= 64'hFFFF_FFFF_FFFF_FFFF;
         timer_intr_q <= 1'b0;
      end else begin
         tick_cnt     <= tick_c ? '0 : tick_cnt + CNT_W'(1);
         mtime        <= mtime_next_c;
         if (wr_c && sel_mtimecmp_c) begin
            mtimecmp <= merge(mtimecmp, bus.i_clint_wdata, bus.i_clint_wmask);
         end
         timer_intr_q <= (mtime >= mtimecmp);
      end
   end

   assign bus.o_clint_ready  = ready_q;
   assign bus.o_clint_rvalid = rvalid_q;
   assign bus.o_clint_rdata  = rdata_q;
   assign o_clint_timer_intr = timer_intr_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer (TICK_DIV=1). Expected responses are queued
// at issue time; a negedge monitor pops and compares every accepted response.
module tb_clint_timer;

   localparam logic [63:0] BASE   = 64'h0200_0000;
   localparam logic [63:0] A_MSIP = BASE;
   localparam logic [63:0] A_CMP  = BASE + 64'h4000;
   localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
   localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef CLINT_MSIP_EN
   localparam logic [63:0] MSIP_EXP = 64'd1;
`else
   localparam logic [63:0] MSIP_EXP = 64'd0;
`endif

   typedef struct packed {
      logic        chk;
      logic [63:0] val;
   } resp_t;

   logic  clk = 1'b0;
   logic  rst_n;
   logic  timer_intr;
   logic  soft_intr;
   int    n_checks = 0;
   int    n_fail   = 0;
   resp_t exp_q[$];

   clint_if bus ();

   clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .bus                (bus),
      .o_clint_timer_intr (timer_intr),
      .o_clint_soft_intr  (soft_intr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor: one pop per accepted response.
   always @(negedge clk) begin
      if (bus.o_clint_rvalid && bus.i_clint_rready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: got rdata %h expected no response",
                     bus.o_clint_rdata);
         end else begin
            resp_t e;
            e = exp_q.pop_front();
            if (e.chk) check("rdata", bus.o_clint_rdata, e.val);
         end
      end
   end

   // One access: accepted on the first edge, response taken on the second.
   task automatic access(input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] mask,
                         input logic chk, input logic [63:0] exp,
                         output logic intr_acc);
      check("ready_idle", 64'(bus.o_clint_ready), 64'd1);
      bus.i_clint_valid = 1'b1;
      bus.i_clint_wen   = wen;
      bus.i_clint_addr  = addr;
      bus.i_clint_wdata = wdata;
      bus.i_clint_wmask = mask;
      @(posedge clk); #1;
      intr_acc          = timer_intr;
      bus.i_clint_valid = 1'b0;
      bus.i_clint_wen   = 1'b0;
      exp_q.push_back('{chk: chk, val: exp});
      bus.i_clint_rready = 1'b1;
      @(posedge clk); #1;
      bus.i_clint_rready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ia;
      rst_n              = 1'b0;
      bus.i_clint_valid  = 1'b0;
      bus.i_clint_wen    = 1'b0;
      bus.i_clint_addr   = 64'd0;
      bus.i_clint_wdata  = 64'd0;
      bus.i_clint_wmask  = 8'd0;
      bus.i_clint_rready = 1'b0;

      // Reset values
      #12;
      check("rst_ready",  64'(bus.o_clint_ready),  64'd1);
      check("rst_rvalid", 64'(bus.o_clint_rvalid), 64'd0);
      check("rst_rdata",  bus.o_clint_rdata,       64'd0);
      check("rst_tintr",  64'(timer_intr),         64'd0);
      check("rst_sintr",  64'(soft_intr),          64'd0);

      // 20 idle edges after release: mtime = 20, no interrupt
      @(negedge clk) rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         check("idle_tintr", 64'(timer_intr), 64'd0);
      end
      access(1'b0, A_TIME, 64'd0, 8'h00, 1'b1, 64'd20, ia);

      // mtime=90 at edge E, mtimecmp=100 at E+2; mtime hits 100 at E+10,
      // so the interrupt first shows after E+11
      access(1'b1, A_TIME, 64'd90, 8'hFF, 1'b0, 64'd0, ia);
      access(1'b1, A_CMP, 64'd100, 8'hFF, 1'b0, 64'd0, ia);
      for (int k = 4; k <= 12; k++) begin
         @(posedge clk); #1;
         check("cmp100_tintr", 64'(timer_intr), (k >= 11) ? 64'd1 : 64'd0);
      end
      // Raise mtimecmp: still set at the commit edge, clear one edge later
      access(1'b1, A_CMP, 64'd1000, 8'hFF, 1'b0, 64'd0, ia);
      check("cmp1000_at_commit", 64'(ia), 64'd1);
      check("cmp1000_after", 64'(timer_intr), 64'd0);

      // Wrap: mtime FE at F, FF at F+1, 0 at F+2 (mtimecmp = all ones)
      access(1'b1, A_CMP, ONES, 8'hFF, 1'b0, 64'd0, ia);
      access(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 1'b0, 64'd0, ia);
      check("wrap_fe_tintr", 64'(timer_intr), 64'd0);
      @(posedge clk); #1;
      check("wrap_ff_tintr", 64'(timer_intr), 64'd1);
      access(1'b0, A_TIME, 64'd0, 8'h00, 1'b1, 64'd0, ia);
      check("wrap_0_tintr", 64'(ia), 64'd0);

      // Held response: accepted at F+5 with mtime = 2
      bus.i_clint_valid = 1'b1;
      bus.i_clint_wen   = 1'b0;
      bus.i_clint_addr  = A_TIME;
      @(posedge clk); #1;
      bus.i_clint_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("hold_rvalid", 64'(bus.o_clint_rvalid), 64'd1);
         check("hold_ready",  64'(bus.o_clint_ready),  64'd0);
         check("hold_rdata",  bus.o_clint_rdata,       64'd2);
      end
      exp_q.push_back('{chk: 1'b1, val: 64'd2});
      bus.i_clint_rready = 1'b1;
      @(posedge clk); #1;
      bus.i_clint_rready = 1'b0;
      check("idle_rdata_zero", bus.o_clint_rdata, 64'd0);

      // Partial mtime write on a tick edge: 0x1FF -> inc 0x200, byte0=0x55
      access(1'b1, A_TIME, 64'h1FE, 8'hFF, 1'b0, 64'd0, ia);
      access(1'b1, A_TIME, 64'h55, 8'h01, 1'b0, 64'd0, ia);
      access(1'b0, A_TIME, 64'd0, 8'h00, 1'b1, 64'h256, ia);

      // Byte-masked mtimecmp write
      access(1'b1, A_CMP, 64'h1234, 8'h01, 1'b0, 64'd0, ia);
      access(1'b0, A_CMP, 64'd0, 8'h00, 1'b1, 64'hFFFF_FFFF_FFFF_FF34, ia);

      // msip
      access(1'b1, A_MSIP, 64'd1, 8'h01, 1'b0, 64'd0, ia);
      check("soft_intr", 64'(soft_intr), MSIP_EXP);
      access(1'b0, A_MSIP, 64'd0, 8'h00, 1'b1, MSIP_EXP, ia);

      // Unmapped address
      access(1'b1, BASE + 64'h8, ONES, 8'hFF, 1'b0, 64'd0, ia);
      access(1'b0, BASE + 64'h8, 64'd0, 8'h00, 1'b1, 64'd0, ia);

      // Reset during RESP abandons the response
      bus.i_clint_valid = 1'b1;
      bus.i_clint_wen   = 1'b0;
      bus.i_clint_addr  = A_TIME;
      @(posedge clk); #1;
      bus.i_clint_valid = 1'b0;
      check("pre_rst_rvalid", 64'(bus.o_clint_rvalid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_rvalid", 64'(bus.o_clint_rvalid), 64'd0);
      check("mid_rst_ready",  64'(bus.o_clint_ready),  64'd1);
      check("mid_rst_rdata",  bus.o_clint_rdata,       64'd0);
      check("mid_rst_sintr",  64'(soft_intr),          64'd0);
      @(negedge clk) rst_n = 1'b1;
      access(1'b0, A_TIME, 64'd0, 8'h00, 1'b1, 64'd0, ia);
      access(1'b0, A_CMP, 64'd0, 8'h00, 1'b1, ONES, ia);

      repeat (2) @(posedge clk);
      #1;
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
